mem_access_stage: RTL

Pipeline MEM stage plus MEM/WB register. Takes the EX/MEM-registered instruction, performs load/store on a handshaked data memory port, extracts and sign/zero-extends load data, and registers everything the write-back mux consumes (mem_to_reg select, ALU result, memory data, PC+4 link address). While an access is outstanding it stalls the upstream pipeline and inserts bubbles into write-back.

---
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage plus MEM/WB register: issues loads/stores on a req/ack data
// memory port, formats load data and stalls the upstream pipeline while an access waits.
module mem_access_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_rs2_data,
   input  logic [31:0] ex_next_sel_address,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic [1:0]  ex_mem_to_reg,
   output logic        stall_o,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [1:0]  wb_mem_to_reg,
   output logic [31:0] wb_alu_out,
   output logic [31:0] wb_data_mem_out,
   output logic [31:0] wb_next_sel_address,
   output logic        misalign_o,
   output logic        dbg_busy_o
);

   // Memory handshake: dmem_req stays high with addr/we/wdata/wstrb stable until the
   // cycle in which dmem_ack is sampled high; that cycle completes the access and
   // carries dmem_rdata. dmem_ack seen while no request is pending is ignored.

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  mem_to_reg;
      logic [31:0] next_sel;
   } hold_t;

   typedef struct packed {
      logic        valid;
      logic        misalign;
      logic        reg_write;
      logic [4:0]  rd;
      logic [1:0]  mem_to_reg;
      logic [31:0] alu_out;
      logic [31:0] data;
      logic [31:0] next_sel;
   } wb_t;

   state_t      state_q, state_d;
   hold_t       hold_q, hold_d;
   wb_t         wb_q, wb_d;

   logic        mem_op;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        aligned;
   logic [3:0]  ex_wstrb;
   logic [31:0] ex_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   // funct3[1:0] selects the size; the unused codes 011/110/111 fall into word
   assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
   assign is_byte = (ex_funct3[1:0] == 2'b00);
   assign is_half = (ex_funct3[1:0] == 2'b01);
   assign is_word = ex_funct3[1];
   assign aligned = !(is_half && ex_alu_out[0]) && !(is_word && (ex_alu_out[1:0] != 2'b00));

   always_comb begin
      ex_wstrb = 4'b1111;
      ex_wdata = ex_rs2_data;
      if (is_byte) begin
         ex_wstrb = 4'b0001 << ex_alu_out[1:0];
         ex_wdata = {4{ex_rs2_data[7:0]}};
      end else if (is_half) begin
         ex_wstrb = 4'b0011 << {ex_alu_out[1], 1'b0};
         ex_wdata = {2{ex_rs2_data[15:0]}};
      end
   end

   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (hold_q.addr[1:0])
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half   = hold_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      // funct3[2] marks the unsigned variants
      if (hold_q.funct3[1:0] == 2'b00) begin
         load_data = {{24{ld_byte[7] & ~hold_q.funct3[2]}}, ld_byte};
      end else if (hold_q.funct3[1:0] == 2'b01) begin
         load_data = {{16{ld_half[15] & ~hold_q.funct3[2]}}, ld_half};
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wb_d    = wb_q;
      stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op && aligned) begin
               state_d           = BUSY;
               stall_o           = 1'b1;
               hold_d.we         = ex_mem_write;
               hold_d.funct3     = ex_funct3;
               hold_d.addr       = ex_alu_out;
               hold_d.wdata      = ex_wdata;
               hold_d.wstrb      = ex_wstrb;
               hold_d.rd         = ex_rd;
               hold_d.reg_write  = ex_reg_write;
               hold_d.mem_to_reg = ex_mem_to_reg;
               hold_d.next_sel   = ex_next_sel_address;
               wb_d.valid        = 1'b0;
               wb_d.misalign     = 1'b0;
            end else begin
               // plain instruction, bubble, or misaligned access reported as a fault
               wb_d.valid      = ex_valid;
               wb_d.misalign   = mem_op;
               wb_d.reg_write  = ex_reg_write & ~mem_op;
               wb_d.rd         = ex_rd;
               wb_d.mem_to_reg = ex_mem_to_reg;
               wb_d.alu_out    = ex_alu_out;
               wb_d.data       = 32'h0;
               wb_d.next_sel   = ex_next_sel_address;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               state_d         = IDLE;
               wb_d.valid      = 1'b1;
               wb_d.misalign   = 1'b0;
               wb_d.reg_write  = hold_q.reg_write;
               wb_d.rd         = hold_q.rd;
               wb_d.mem_to_reg = hold_q.mem_to_reg;
               wb_d.alu_out    = hold_q.addr;
               wb_d.data       = hold_q.we ? 32'h0 : load_data;
               wb_d.next_sel   = hold_q.next_sel;
            end else begin
               stall_o    = 1'b1;
               wb_d.valid = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem_req   = (state_q == BUSY);
   assign dmem_we    = hold_q.we;
   assign dmem_addr  = {hold_q.addr[31:2], 2'b00};
   assign dmem_wdata = hold_q.wdata;
   assign dmem_wstrb = hold_q.wstrb;
   assign dbg_busy_o = (state_q == BUSY);

   assign wb_valid            = wb_q.valid;
   assign misalign_o          = wb_q.misalign;
   assign wb_reg_write        = wb_q.reg_write;
   assign wb_rd               = wb_q.rd;
   assign wb_mem_to_reg       = wb_q.mem_to_reg;
   assign wb_alu_out          = wb_q.alu_out;
   assign wb_data_mem_out     = wb_q.data;
   assign wb_next_sel_address = wb_q.next_sel;

endmodule
